// File: rtl/hex_display_scheduler_pkg.sv
// Shared segment codes, scheduler FSM states and the BCD-digit to seven-segment decoder.
// All segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package hex_sched_pkg;

  localparam int DATA_W = 8;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    SELECT  = 2'd0,
    LATCH   = 2'd1,
    CONVERT = 2'd2,
    SHOW    = 2'd3
  } state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/hex_display_scheduler_bin2bcd.sv
// bin2bcd_seq: 8-bit sequential double-dabble, one shift-add-3 step per cycle, 8 cycles.
// done is asserted during the final step and bcd carries that step's result in the same cycle.
module bin2bcd_seq
  import hex_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [11:0]       bcd
);

  logic [7:0]  sh;
  logic [11:0] acc;
  logic [11:0] adj;
  logic [19:0] nxt;
  logic [2:0]  cnt;

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    adj  = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
    nxt  = {adj, sh} << 1;
    bcd  = nxt[19:8];
    done = busy && (cnt == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= 3'd0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= 3'd0;
    end else if (busy) begin
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) busy <= 1'b0;
    end
  end

  // shift datapath: no reset, only meaningful while busy
  always_ff @(posedge clk) begin
    if (start) begin
      sh  <= bin;
      acc <= 12'd0;
    end else if (busy) begin
      sh  <= nxt[7:0];
      acc <= nxt[19:8];
    end
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Round-robin scheduler putting one of N_SRC 8-bit values on three decimal HEX digits plus an index digit.
// Optional macro HEX_SCHED_LZB_EN enables leading-zero blanking of the hundreds/tens digits.
module hex_display_scheduler
  import hex_sched_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int SRC_W        = $clog2(N_SRC),
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic                  clk50,
  input  logic                  rst,
  input  logic [N_SRC*8-1:0]    src_val,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic                  key_next,
  input  logic                  hold,
  output logic [SRC_W-1:0]      cur_src,
  output logic [6:0]            hex_h,
  output logic [6:0]            hex_m,
  output logic [6:0]            hex_l,
  output logic [6:0]            hex_src
);

  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

  state_t             state, state_n;
  logic               fresh;
  logic               key_q, key_edge;
  logic               pending;
  logic [DW_W-1:0]    dwell;
  logic [DATA_W-1:0]  val_q, cur_val;
  logic               found;
  logic [SRC_W-1:0]   sel_idx;
  int                 base;
  logic               expiry, advance;
  logic               conv_start, conv_busy, conv_done;
  logic [11:0]        bcd;
  logic [6:0]         dig_h, dig_m, dig_l;

  bin2bcd_seq u_bcd (
    .clk   (clk50),
    .rst   (rst),
    .start (conv_start),
    .bin   (cur_val),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  assign cur_val  = src_val[{cur_src, 3'b000} +: 8];
  assign key_edge = key_next & ~key_q;
  assign expiry   = (dwell == DWELL_LAST) && !hold;
  assign advance  = expiry || key_edge || pending || !src_valid[cur_src];

  // Search starts after the current source so it is the last candidate; the very first
  // search after reset starts at source 0.
  always_comb begin
    found   = 1'b0;
    sel_idx = cur_src;
    base    = fresh ? 0 : int'(cur_src) + 1;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && src_valid[(base + k) % N_SRC]) begin
        found   = 1'b1;
        sel_idx = SRC_W'((base + k) % N_SRC);
      end
    end
  end

  always_comb begin
`ifdef HEX_SCHED_LZB_EN
    dig_h = (bcd[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd[11:8]);
    dig_m = (bcd[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd[7:4]);
`else
    dig_h = seg7(bcd[11:8]);
    dig_m = seg7(bcd[7:4]);
`endif
    dig_l = seg7(bcd[3:0]);
  end

  always_comb begin
    state_n    = state;
    conv_start = 1'b0;
    case (state)
      SELECT:  if (found) state_n = LATCH;
      LATCH: begin
        conv_start = 1'b1;
        state_n    = CONVERT;
      end
      CONVERT: begin
        if (conv_done)       state_n = SHOW;
        else if (!conv_busy) state_n = LATCH;
      end
      SHOW: begin
        if (advance)                state_n = SELECT;
        else if (cur_val != val_q)  state_n = LATCH;
      end
      default: state_n = SELECT;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state   <= SELECT;
      cur_src <= '0;
      fresh   <= 1'b1;
      dwell   <= '0;
      pending <= 1'b0;
      key_q   <= 1'b0;
      val_q   <= '0;
      hex_h   <= SEG_BLANK;
      hex_m   <= SEG_BLANK;
      hex_l   <= SEG_BLANK;
      hex_src <= SEG_BLANK;
    end else begin
      state <= state_n;
      key_q <= key_next;
      case (state)
        SELECT: begin
          if (found) begin
            cur_src <= sel_idx;
            dwell   <= '0;
            fresh   <= 1'b0;
          end else begin
            hex_h <= SEG_DASH;
            hex_m <= SEG_DASH;
            hex_l <= SEG_DASH;
          end
        end
        LATCH: begin
          val_q <= cur_val;
          if (key_edge) pending <= 1'b1;
        end
        CONVERT: begin
          if (key_edge) pending <= 1'b1;
          // all four digits change together on the final conversion step
          if (conv_done) begin
            hex_h   <= dig_h;
            hex_m   <= dig_m;
            hex_l   <= dig_l;
            hex_src <= seg7(4'(cur_src));
          end
        end
        SHOW: begin
          if (!hold)   dwell   <= dwell + 1'b1;
          if (advance) pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler (4 sources, 64-cycle dwell, default build).
module tb_hex_display_scheduler;

  logic        clk50 = 1'b0;
  logic        rst;
  logic [31:0] src_val;
  logic [3:0]  src_valid;
  logic        key_next;
  logic        hold;
  logic [1:0]  cur_src;
  logic [6:0]  hex_h, hex_m, hex_l, hex_src;

  int n_tests = 0;
  int n_fail  = 0;
  int cnow    = 0;

  hex_display_scheduler #(
    .N_SRC        (4),
    .SRC_W        (2),
    .DWELL_CYCLES (64)
  ) dut (
    .clk50     (clk50),
    .rst       (rst),
    .src_val   (src_val),
    .src_valid (src_valid),
    .key_next  (key_next),
    .hold      (hold),
    .cur_src   (cur_src),
    .hex_h     (hex_h),
    .hex_m     (hex_m),
    .hex_l     (hex_l),
    .hex_src   (hex_src)
  );

  always #5 clk50 = ~clk50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cnow, got, exp);
    end
  endtask

  // advance to the start of cycle c, sampling 1 time unit after the edge
  task automatic go(input int c);
    while (cnow < c) begin
      @(posedge clk50);
      #1;
      cnow++;
    end
  endtask

  task automatic digits(input string tag, input logic [6:0] h, input logic [6:0] m,
                        input logic [6:0] l);
    check({tag, "_h"}, 32'(hex_h), 32'(h));
    check({tag, "_m"}, 32'(hex_m), 32'(m));
    check({tag, "_l"}, 32'(hex_l), 32'(l));
  endtask

  initial begin
    rst       = 1'b1;
    src_val   = {8'd0, 8'd255, 8'd7, 8'd45};
    src_valid = 4'b1111;
    key_next  = 1'b0;
    hold      = 1'b0;
    repeat (3) @(posedge clk50);
    #1;
    check("rst_cur_src", 32'(cur_src), 0);
    digits("rst", 7'h7F, 7'h7F, 7'h7F);
    check("rst_hex_src", 32'(hex_src), 32'h7F);
    rst  = 1'b0;
    cnow = 0;

    go(9);
    check("first_not_yet", 32'(hex_l), 32'h7F);
    go(10);
    digits("first45", 7'h40, 7'h19, 7'h12);
    check("first_src", 32'(cur_src), 0);
    check("first_hex_src", 32'(hex_src), 32'h40);

    // dwell expiry at c73, new index at c75, new digits at c84
    go(74);  check("dwell_keep0", 32'(cur_src), 0);
    go(75);  check("dwell_to1", 32'(cur_src), 1);
    go(83);  check("old_held", 32'(hex_l), 32'h12);
    go(84);  digits("src1_7", 7'h40, 7'h40, 7'h78);
    check("src1_hex_src", 32'(hex_src), 32'h79);
    go(158); digits("src2_255", 7'h24, 7'h12, 7'h12);
    check("src2_idx", 32'(cur_src), 2);
    check("src2_hex_src", 32'(hex_src), 32'h24);
    go(232); digits("src3_0", 7'h40, 7'h40, 7'h40);
    check("src3_idx", 32'(cur_src), 3);
    go(306); digits("wrap_45", 7'h40, 7'h19, 7'h12);
    check("wrap_idx", 32'(cur_src), 0);

    // value change 45->46 at c316; dwell keeps its 11 counted cycles
    go(316); src_val[7:0] = 8'd46;
    go(325); check("chg_old", 32'(hex_l), 32'h12);
    go(326); digits("chg_46", 7'h40, 7'h19, 7'h02);
    go(379); check("chg_dwell_kept0", 32'(cur_src), 0);
    go(380); check("chg_dwell_kept1", 32'(cur_src), 1);
    go(389); check("chg_next_l", 32'(hex_l), 32'h78);

    // hold for 200 cycles with 10 dwell cycles already counted
    go(399); hold = 1'b1;
    go(598); check("hold_no_adv", 32'(cur_src), 1);
    go(599); hold = 1'b0;
    go(653); check("hold_rem0", 32'(cur_src), 1);
    go(654); check("hold_rem1", 32'(cur_src), 2);
    go(663); digits("hold_255", 7'h24, 7'h12, 7'h12);

    // key edge coincident with dwell expiry at c726
    go(726); key_next = 1'b1;
    go(728); check("key_exp_adv", 32'(cur_src), 3);
    go(730); key_next = 1'b0;
    go(737); digits("key_exp_dig", 7'h40, 7'h40, 7'h40);
    go(760); check("key_exp_single", 32'(cur_src), 3);

    // two key edges during CONVERT (c803..c810) collapse into one advance at c811
    go(802); check("conv_idx0", 32'(cur_src), 0);
    go(805); key_next = 1'b1;
    go(806); key_next = 1'b0;
    go(807); key_next = 1'b1;
    go(808); key_next = 1'b0;
    go(811); check("pend_show_l", 32'(hex_l), 32'h02);
    check("pend_show_idx", 32'(cur_src), 0);
    go(813); check("pend_adv", 32'(cur_src), 1);
    go(822); check("pend_dig", 32'(hex_l), 32'h78);
    check("pend_single", 32'(cur_src), 1);

    // valid mask 0101: source 1 drops, rotation 2 -> 0
    src_valid = 4'b0101;
    go(824); check("mask_to2", 32'(cur_src), 2);
    go(833); digits("mask_255", 7'h24, 7'h12, 7'h12);
    go(898); check("mask_to0", 32'(cur_src), 0);
    go(907); check("mask_dig", 32'(hex_l), 32'h02);

    // no valid source: dashes, index unchanged
    src_valid = 4'b0000;
    go(909); digits("none", 7'h3F, 7'h3F, 7'h3F);
    check("none_idx", 32'(cur_src), 0);
    go(920); digits("none_late", 7'h3F, 7'h3F, 7'h3F);
    check("none_idx_late", 32'(cur_src), 0);
    src_valid = 4'b0100;
    go(921); check("revalid_idx", 32'(cur_src), 2);
    go(930); digits("revalid_dig", 7'h24, 7'h12, 7'h12);

    // change src2 to 123, reset on the 4th CONVERT cycle (c935)
    src_val[23:16] = 8'd123;
    go(935); rst = 1'b1;
    go(936); digits("rst_mid", 7'h7F, 7'h7F, 7'h7F);
    check("rst_mid_src", 32'(hex_src), 32'h7F);
    check("rst_mid_idx", 32'(cur_src), 0);
    rst = 1'b0;
    go(945); check("rst_no_stale", 32'(hex_h), 32'h7F);
    go(946); digits("after_rst_123", 7'h79, 7'h24, 7'h30);
    check("after_rst_idx", 32'(cur_src), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
